// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding, effective-length helper and idle line level
package seq_gen_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  localparam logic IDLE_LVL_DEF = 1'b0;
  function automatic int eff_len(int len, int width);
    return (len == 0 || len > width) ? width : len;
  endfunction
endpackage

// File: rtl/seq_piso.sv
// seq_piso: MSB-first load/shift register whose MSB is the bit currently on the line
module seq_piso #(
  parameter int   WIDTH    = 8,
  parameter int   LEN_W    = $clog2(WIDTH) + 1,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic [LEN_W-1:0] len_in,
  output logic             q,
  output logic [LEN_W-1:0] cnt,
  output logic [LEN_W-1:0] len
);
  logic [WIDTH-1:0] dat, sreg;
  assign q = sreg[WIDTH-1];
  // Bit L-1 is aligned to the MSB; any cycle without load/reload/shift parks the line at idle level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dat  <= '0;
      len  <= '0;
      sreg <= {WIDTH{IDLE_LVL}};
      cnt  <= '0;
    end else if (load) begin
      dat  <= d;
      len  <= len_in;
      sreg <= d << (LEN_W'(WIDTH) - len_in);
      cnt  <= len_in - 1'b1;
    end else if (reload) begin
      sreg <= dat << (LEN_W'(WIDTH) - len);
      cnt  <= len - 1'b1;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], IDLE_LVL};
      cnt  <= cnt - 1'b1;
    end else begin
      sreg <= {WIDTH{IDLE_LVL}};
      cnt  <= '0;
    end
  end
endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: handshake-loaded serial pattern transmitter with repeats and inter-repeat gaps
module sequence_generator import seq_gen_pkg::*; #(
  parameter int   WIDTH    = 8,
  parameter int   LEN_W    = $clog2(WIDTH) + 1,
  parameter int   REP_W    = 4,
  parameter int   GAP      = 1,
  parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic [REP_W-1:0] in_rep,
  output logic             x,
  output logic             x_valid,
  output logic             x_first,
  output logic             x_last,
  output logic             busy
);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  state_t           state;
  logic [REP_W-1:0] rep;
  logic [GW-1:0]    gcnt;
  logic [LEN_W-1:0] eff, cnt, len;
  logic             acc, end_rep, load, reload, shift;
  assign busy = state != S_IDLE;
  always_comb begin
    eff      = LEN_W'(eff_len(int'(in_len), WIDTH));
    end_rep  = state == S_SHIFT && cnt == '0;
    in_ready = reset && !abort && (state == S_IDLE || (GAP == 0 && end_rep && rep == '0));
    acc      = in_valid && in_ready;
    load     = acc;
    reload   = !abort && !acc && ((GAP == 0 && end_rep && rep != '0) || (state == S_GAP && gcnt == '0));
    shift    = !abort && !acc && state == S_SHIFT && !end_rep;
  end
  seq_piso #(.WIDTH(WIDTH), .LEN_W(LEN_W), .IDLE_LVL(IDLE_LVL)) u_piso (
    .clk(clk), .reset(reset), .load(load), .reload(reload), .shift(shift),
    .d(in_data), .len_in(eff), .q(x), .cnt(cnt), .len(len)
  );
  // Flags describe the bit that the piso will present after this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      rep     <= '0;
      gcnt    <= '0;
      x_valid <= 1'b0;
      x_first <= 1'b0;
      x_last  <= 1'b0;
    end else if (abort) begin
      state   <= S_IDLE;
      x_valid <= 1'b0;
      x_first <= 1'b0;
      x_last  <= 1'b0;
    end else if (acc) begin
      state   <= S_SHIFT;
      rep     <= in_rep;
      x_valid <= 1'b1;
      x_first <= 1'b1;
      x_last  <= eff == LEN_W'(1) && in_rep == '0;
    end else if (state == S_SHIFT && !end_rep) begin
      x_first <= 1'b0;
      x_last  <= cnt == LEN_W'(1) && rep == '0;
    end else if (end_rep && rep != '0) begin
      rep     <= rep - 1'b1;
      state   <= GAP == 0 ? S_SHIFT : S_GAP;
      gcnt    <= GW'(GAP - 1);
      x_valid <= GAP == 0;
      x_first <= GAP == 0;
      x_last  <= GAP == 0 && len == LEN_W'(1) && rep == REP_W'(1);
    end else if (end_rep) begin
      state   <= S_IDLE;
      x_valid <= 1'b0;
      x_first <= 1'b0;
      x_last  <= 1'b0;
    end else if (state == S_GAP) begin
      if (gcnt == '0) begin
        state   <= S_SHIFT;
        x_valid <= 1'b1;
        x_first <= 1'b1;
        x_last  <= len == LEN_W'(1) && rep == '0;
      end else begin
        gcnt <= gcnt - 1'b1;
      end
    end
  end
endmodule
